// File: rtl/fc_out_serializer.sv
// Captures a vector of signed accumulators, requantizes every lane in one edge
// (shift, optional ReLU, saturate) and streams the lanes out one per transfer.
module fc_out_serializer #(
  parameter int NUM_NEURONS = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int FRAC_BITS   = 8,
  parameter int RELU_EN     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_in,
  output logic                             in_ready,
  input  logic [NUM_NEURONS*ACC_WIDTH-1:0] fc_in,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             valid_out,
  input  logic                             out_ready,
  output logic                             last_out,
  output logic                             sat_flag
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
  localparam bit RELU_ON = (RELU_EN != 32'sd0);

  // Saturation limits expressed at accumulator width so comparisons stay signed.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OUT_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  function automatic logic signed [ACC_WIDTH-1:0] shift_acc(input logic [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] acc_sv;
    acc_sv = signed'(acc);
    return acc_sv >>> FRAC_BITS;
  endfunction

  function automatic logic lane_ovf(input logic signed [ACC_WIDTH-1:0] sh);
    return (sh > SAT_MAX) || (sh < SAT_MIN);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] sh);
    logic [DATA_WIDTH-1:0] res;
    if (RELU_ON && sh[ACC_WIDTH-1]) begin
      res = OUT_ZERO;
    end else if (sh > SAT_MAX) begin
      res = OUT_MAX;
    end else if (sh < SAT_MIN) begin
      res = OUT_MIN;
    end else begin
      res = sh[DATA_WIDTH-1:0];
    end
    return res;
  endfunction

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0]       data_out_q, data_out_d;
  logic                        valid_out_q, valid_out_d;
  logic                        last_out_q, last_out_d;
  logic                        sat_q, sat_d;
  logic [DATA_WIDTH-1:0]       buf_q [NUM_NEURONS];

  logic signed [ACC_WIDTH-1:0] sh_s  [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]       rq_s  [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]      ovf_s;
  logic [IDX_W-1:0]            idx_inc_s;
  logic                        in_ready_s;
  logic                        accept_s;
  logic                        xfer_s;

  // Per-lane requantization of the incoming vector.
  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      sh_s[i]  = shift_acc(fc_in[i*ACC_WIDTH +: ACC_WIDTH]);
      rq_s[i]  = requant(sh_s[i]);
      ovf_s[i] = lane_ovf(sh_s[i]);
    end
  end

  // The last lane leaving frees the buffer, so a new vector may land on that same edge.
  assign in_ready_s = ~rst & ((state_q == S_IDLE) | ((idx_q == LAST_IDX) & out_ready));
  assign accept_s   = valid_in & in_ready_s;
  assign xfer_s     = valid_out_q & out_ready;
  assign idx_inc_s  = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
  assign sat_d      = sat_q | (accept_s & (|ovf_s));

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d     = S_STREAM;
          idx_d       = ZERO_IDX;
          data_out_d  = rq_s[0];
          valid_out_d = 1'b1;
          last_out_d  = (LAST_IDX == ZERO_IDX);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (xfer_s && (idx_q == LAST_IDX)) begin
          if (accept_s) begin
            state_d     = S_STREAM;
            idx_d       = ZERO_IDX;
            data_out_d  = rq_s[0];
            valid_out_d = 1'b1;
            last_out_d  = (LAST_IDX == ZERO_IDX);
          end else begin
            state_d     = S_IDLE;
            valid_out_d = 1'b0;
            last_out_d  = 1'b0;
          end
        end else if (xfer_s) begin
          idx_d      = idx_inc_s;
          data_out_d = buf_q[idx_inc_s];
          last_out_d = (idx_inc_s == LAST_IDX);
        end else begin
          state_d = S_STREAM;
        end
      end
      default: begin
        state_d     = S_IDLE;
        valid_out_d = 1'b0;
        last_out_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= ZERO_IDX;
      data_out_q  <= OUT_ZERO;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
      sat_q       <= sat_d;
    end
  end

  // Requantized lane buffer, reloaded whole on every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        buf_q[i] <= OUT_ZERO;
      end
    end else if (accept_s) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        buf_q[i] <= rq_s[i];
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fc_out_serializer.sv
// Bench: two instances (ReLU on / off) driven identically and compared each
// cycle against a queue-based model of the lanes still waiting to be sent.
module tb_fc_out_serializer;
  localparam int NN = 16;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int FB = 8;
  localparam longint MAXV = (64'sd1 <<< (DW-1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (DW-1));

  logic clk = 1'b0;
  logic rst, valid_in, out_ready;
  logic [NN*AW-1:0] fc_in;
  logic in_ready_r, valid_out_r, last_out_r, sat_flag_r;
  logic in_ready_n, valid_out_n, last_out_n, sat_flag_n;
  logic [DW-1:0] data_out_r, data_out_n;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] qr[$];
  logic [DW-1:0] qn[$];
  logic [DW-1:0] held_r = '0;
  logic [DW-1:0] held_n = '0;
  bit m_sat = 1'b0;

  always #5 clk = ~clk;

  fc_out_serializer #(.NUM_NEURONS(NN), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
                      .FRAC_BITS(FB), .RELU_EN(1)) dut_r (
    .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready_r), .fc_in(fc_in),
    .data_out(data_out_r), .valid_out(valid_out_r), .out_ready(out_ready),
    .last_out(last_out_r), .sat_flag(sat_flag_r));

  fc_out_serializer #(.NUM_NEURONS(NN), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
                      .FRAC_BITS(FB), .RELU_EN(0)) dut_n (
    .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready_n), .fc_in(fc_in),
    .data_out(data_out_n), .valid_out(valid_out_n), .out_ready(out_ready),
    .last_out(last_out_n), .sat_flag(sat_flag_n));

  function automatic longint floor_div(logic [AW-1:0] a);
    longint v, d;
    v = longint'($signed(a));
    d = 64'sd1 <<< FB;
    if (v >= 64'sd0) return v / d;
    else return -((-v + d - 64'sd1) / d);
  endfunction

  function automatic logic [DW-1:0] ref_elem(logic [AW-1:0] a, bit relu);
    longint q;
    logic [63:0] qb;
    q = floor_div(a);
    if (relu && q < 64'sd0) q = 64'sd0;
    if (q > MAXV) q = MAXV;
    else if (q < MINV) q = MINV;
    qb = q;
    return qb[DW-1:0];
  endfunction

  function automatic bit ref_ovf(logic [AW-1:0] a);
    longint q;
    q = floor_div(a);
    return (q > MAXV) || (q < MINV);
  endfunction

  function automatic logic [AW-1:0] rand_acc();
    logic [AW-1:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1: return {{8{r[23]}}, r[23:0]};
      2: return {{7{r[24]}}, r[24:0]};
      default: return {{16{r[15]}}, r[15:0]};
    endcase
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NN; i++) fc_in[i*AW +: AW] = rand_acc();
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic cycle();
    bit er, acc, xf;
    logic [NN*AW-1:0] snap;
    logic [AW-1:0] a;
    #1;
    er = !rst && (qr.size() == 0 || (qr.size() == 1 && out_ready));
    chk("in_ready_r", in_ready_r, er);
    chk("in_ready_n", in_ready_n, er);
    acc  = valid_in && er;
    xf   = (qr.size() > 0) && out_ready;
    snap = fc_in;
    @(posedge clk);
    #1;
    if (rst) begin
      qr.delete(); qn.delete();
      held_r = '0; held_n = '0; m_sat = 1'b0;
    end else begin
      if (xf) begin
        void'(qr.pop_front());
        void'(qn.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < NN; i++) begin
          a = snap[i*AW +: AW];
          qr.push_back(ref_elem(a, 1'b1));
          qn.push_back(ref_elem(a, 1'b0));
          if (ref_ovf(a)) m_sat = 1'b1;
        end
      end
      if (qr.size() > 0) begin
        held_r = qr[0];
        held_n = qn[0];
      end
    end
    chk("valid_out_r", valid_out_r, qr.size() > 0);
    chk("valid_out_n", valid_out_n, qn.size() > 0);
    chk("last_out_r", last_out_r, qr.size() == 1);
    chk("last_out_n", last_out_n, qn.size() == 1);
    chk("data_out_r", data_out_r, held_r);
    chk("data_out_n", data_out_n, held_n);
    chk("sat_flag_r", sat_flag_r, m_sat);
    chk("sat_flag_n", sat_flag_n, m_sat);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; out_ready = 1'b0; fc_in = '0;
    repeat (2) cycle();
    rst = 1'b0; out_ready = 1'b1;

    // basic ramp stream
    for (int i = 0; i < NN; i++) fc_in[i*AW +: AW] = i * 256;
    valid_in = 1'b1; cycle();
    valid_in = 1'b0; repeat (17) cycle();
    chk("basic_sat", sat_flag_r, 1'b0);

    // saturation and ReLU corner lanes
    for (int i = 0; i < NN; i++) fc_in[i*AW +: AW] = i * 256;
    fc_in[0*AW +: AW] = 32'h7FFF_FFFF;
    fc_in[1*AW +: AW] = 32'hF000_0000;
    fc_in[2*AW +: AW] = 32'hFFFF_FFFF;
    valid_in = 1'b1; cycle();
    valid_in = 1'b0;
    chk("sat_lane0", data_out_r, 16'h7FFF);
    chk("sat_flag_set", sat_flag_r, 1'b1);
    cycle();
    chk("relu_lane1", data_out_r, 16'h0000);
    chk("norelu_lane1", data_out_n, 16'h8000);
    cycle();
    chk("norelu_lane2", data_out_n, 16'hFFFF);
    chk("relu_lane2", data_out_r, 16'h0000);
    repeat (14) cycle();

    // backpressure at lane 4
    rst = 1'b1; cycle(); rst = 1'b0;
    fill_random(); valid_in = 1'b1; cycle();
    repeat (4) begin fill_random(); cycle(); end
    out_ready = 1'b0;
    repeat (3) begin fill_random(); cycle(); end
    out_ready = 1'b1; valid_in = 1'b0;
    repeat (12) cycle();

    // back-to-back vectors
    valid_in = 1'b1;
    fill_random(); cycle();
    repeat (40) begin
      fill_random(); cycle();
      chk("b2b_valid", valid_out_r, 1'b1);
    end
    valid_in = 1'b0; repeat (17) cycle();

    // reset mid-stream at lane 7, colliding with accept and transfer
    fill_random(); valid_in = 1'b1; cycle();
    valid_in = 1'b0; repeat (7) cycle();
    rst = 1'b1; valid_in = 1'b1; fill_random(); cycle();
    rst = 1'b0; valid_in = 1'b0; cycle();
    chk("rst_valid", valid_out_r, 1'b0);
    chk("rst_sat", sat_flag_r, 1'b0);
    fill_random(); valid_in = 1'b1; cycle();
    valid_in = 1'b0; repeat (17) cycle();

    // random traffic
    repeat (600) begin
      rst       = ($urandom_range(0, 99) == 0);
      valid_in  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 9) < 7);
      fill_random();
      cycle();
    end
    rst = 1'b0; valid_in = 1'b0; out_ready = 1'b1;
    repeat (20) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
